// File: rtl/lock_key_pkg.sv
// rtl/lock_key_pkg.sv - shared widths, state encoding and key layout for the c432 key loader
package lock_key_pkg;

  localparam int MUX_W = 4;
  localparam int XOR_W = 23;
  localparam int KEY_W = MUX_W + XOR_W;
  localparam int CRC_W = 8;
  localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    CRC   = 3'd2,
    CHECK = 3'd3,
    APPLY = 3'd4,
    ERR   = 3'd5
  } state_e;

  // x declared first so that key bit 0 lands in p[0] when a flat key is cast to key_t
  typedef struct packed {
    logic [XOR_W-1:0] x;
    logic [MUX_W-1:0] p;
  } key_t;

endpackage

// File: rtl/crc8_serial.sv
// rtl/crc8_serial.sv - bit-serial CRC-8, MSB-first, zero init, synchronous clear
module crc8_serial #(
  parameter logic [7:0] POLY = 8'h07
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;
  logic       fb;

  always_comb begin
    fb    = crc_q[7] ^ bit_i;
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = '0;
    end else if (en_i) begin
      crc_d = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/lock_key_loader.sv
// rtl/lock_key_loader.sv - serial key receiver that releases the c432 unlock key only after a good CRC
module lock_key_loader
  import lock_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             bit_i,
  input  logic             bit_vld_i,
  output logic             bit_rdy_o,
  output logic [MUX_W-1:0] p_o,
  output logic [XOR_W-1:0] x_o,
  output logic             key_vld_o,
  output logic             key_err_o,
  output logic             busy_o
);

  localparam logic [4:0] KEY_LAST = 5'(KEY_W - 1);
  localparam logic [4:0] CRC_LAST = 5'(CRC_W - 1);

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [KEY_W-1:0] shadow_q, shadow_d;
  key_t             key_out_q, key_out_d;
  logic             key_vld_q, key_vld_d;
  logic             key_err_q, key_err_d;
  logic             crc_clr, crc_en;
  logic [7:0]       crc;
  logic             xfer;

  // start_i wins over a same-cycle transfer, so a bit offered alongside start is dropped
  assign bit_rdy_o = (state_q == SHIFT) || (state_q == CRC);
  assign xfer      = bit_vld_i & bit_rdy_o & ~start_i;
  assign busy_o    = (state_q == SHIFT) || (state_q == CRC) || (state_q == CHECK);

  crc8_serial #(
    .POLY (CRC_POLY)
  ) u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (crc_clr),
    .en_i  (crc_en),
    .bit_i (bit_i),
    .crc_o (crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = SHIFT;
    end else begin
      case (state_q)
        SHIFT:   if (xfer && (cnt_q == KEY_LAST)) state_d = CRC;
        CRC:     if (xfer && (cnt_q == CRC_LAST)) state_d = CHECK;
        CHECK:   state_d = (crc == 8'h00) ? APPLY : ERR;
        APPLY:   state_d = IDLE;
        ERR:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    key_out_d = key_out_q;
    key_vld_d = key_vld_q;
    key_err_d = key_err_q;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    if (start_i) begin
      cnt_d     = '0;
      shadow_d  = '0;
      key_out_d = '0;
      key_vld_d = 1'b0;
      key_err_d = 1'b0;
      crc_clr   = 1'b1;
    end else begin
      case (state_q)
        SHIFT: begin
          if (xfer) begin
            shadow_d[cnt_q] = bit_i;
            crc_en          = 1'b1;
            cnt_d           = (cnt_q == KEY_LAST) ? 5'd0 : cnt_q + 5'd1;
          end
        end
        CRC: begin
          if (xfer) begin
            crc_en = 1'b1;
            cnt_d  = (cnt_q == CRC_LAST) ? 5'd0 : cnt_q + 5'd1;
          end
        end
        APPLY: begin
          key_out_d = key_t'(shadow_q);
          key_vld_d = 1'b1;
        end
        ERR: begin
          key_err_d = 1'b1;
          shadow_d  = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      shadow_q  <= '0;
      key_out_q <= '0;
      key_vld_q <= 1'b0;
      key_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      key_out_q <= key_out_d;
      key_vld_q <= key_vld_d;
      key_err_q <= key_err_d;
    end
  end

  assign p_o       = key_out_q.p;
  assign x_o       = key_out_q.x;
  assign key_vld_o = key_vld_q;
  assign key_err_o = key_err_q;

endmodule

// File: tb/tb_lock_key_loader.sv
// tb/tb_lock_key_loader.sv - scoreboard bench for lock_key_loader with a polynomial-division CRC model
module tb_lock_key_loader;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        bit_i;
  logic        bit_vld_i;
  logic        bit_rdy_o;
  logic [3:0]  p_o;
  logic [22:0] x_o;
  logic        key_vld_o;
  logic        key_err_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int zero_viol = 0;

  typedef struct {
    logic        vld;
    logic        err;
    logic [3:0]  p;
    logic [22:0] x;
    int          at_cyc;
  } exp_t;

  exp_t exp_q[$];

  lock_key_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .bit_i     (bit_i),
    .bit_vld_i (bit_vld_i),
    .bit_rdy_o (bit_rdy_o),
    .p_o       (p_o),
    .x_o       (x_o),
    .key_vld_o (key_vld_o),
    .key_err_o (key_err_o),
    .busy_o    (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Message as a 35-term polynomial, leading term = first bit sent; divide by x^8+x^2+x+1
  function automatic logic [34:0] divide(input logic [26:0] key, input logic [7:0] crc);
    logic [34:0] m;
    logic [8:0]  g;
    g = 9'h107;
    for (int i = 0; i < 27; i++) m[i] = key[i];
    for (int i = 0; i < 8; i++) m[27 + i] = crc[7 - i];
    for (int i = 0; i < 27; i++) begin
      if (m[i]) begin
        for (int j = 0; j <= 8; j++) m[i + j] = m[i + j] ^ g[8 - j];
      end
    end
    return m;
  endfunction

  function automatic logic [7:0] model_crc(input logic [26:0] key);
    logic [34:0] m;
    logic [7:0]  r;
    m = divide(key, 8'h00);
    for (int i = 0; i < 8; i++) r[7 - i] = m[27 + i];
    return r;
  endfunction

  function automatic logic model_good(input logic [26:0] key, input logic [7:0] crc);
    logic [34:0] m;
    m = divide(key, crc);
    return (m[34:27] == 8'h00);
  endfunction

  task automatic xfer(input logic b, input int gap_pct, output int acc_cyc);
    int n;
    if ($urandom_range(99) < gap_pct) begin
      bit_vld_i = 1'b0;
      bit_i     = 1'($urandom);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    bit_vld_i = 1'b1;
    bit_i     = b;
    n = 0;
    while (!bit_rdy_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bit_rdy_o) chk("rdy_timeout", 64'(n), 64'd0);
    acc_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start_i   = 1'b1;
    bit_vld_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_bits(input logic [26:0] key, input logic [7:0] crc, input int nbits,
                           input int gap_pct, output int acc_cyc);
    for (int n = 0; n < nbits; n++) begin
      if (n < 27) xfer(key[n], gap_pct, acc_cyc);
      else        xfer(crc[34 - n], gap_pct, acc_cyc);
    end
    bit_vld_i = 1'b0;
  endtask

  task automatic load(input logic [26:0] key, input logic [7:0] crc, input int gap_pct);
    int   acc;
    exp_t e;
    logic good;
    good = model_good(key, crc);
    pulse_start();
    for (int n = 0; n < 34; n++) begin
      if (n < 27) xfer(key[n], gap_pct, acc);
      else        xfer(crc[34 - n], gap_pct, acc);
    end
    xfer(crc[0], gap_pct, acc);
    bit_vld_i = 1'b0;
    e.vld    = good;
    e.err    = !good;
    e.p      = good ? key[3:0] : 4'h0;
    e.x      = good ? key[26:4] : 23'h0;
    e.at_cyc = acc + 3;
    exp_q.push_back(e);
    repeat (5) @(negedge clk);
  endtask

  logic pv, pe;
  always @(negedge clk) begin
    if (busy_o && (p_o != 4'h0 || x_o != 23'h0)) zero_viol++;
    if (rst_n && ((key_vld_o && !pv) || (key_err_o && !pe))) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_key_vld", 64'(key_vld_o), 64'(e.vld));
        chk("sb_key_err", 64'(key_err_o), 64'(e.err));
        chk("sb_p", 64'(p_o), 64'(e.p));
        chk("sb_x", 64'(x_o), 64'(e.x));
        chk("sb_latency_cyc", 64'(cyc), 64'(e.at_cyc));
      end
    end
    pv = key_vld_o;
    pe = key_err_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [26:0] key;
    logic [7:0]  crc;
    logic [3:0]  p_hold;
    logic [22:0] x_hold;
    int          acc;

    rst_n = 1'b0; start_i = 1'b0; bit_i = 1'b0; bit_vld_i = 1'b0;
    pv = 1'b0; pe = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_p", 64'(p_o), 64'd0);
    chk("rst_x", 64'(x_o), 64'd0);
    chk("rst_vld", 64'(key_vld_o), 64'd0);
    chk("rst_err", 64'(key_err_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_rdy", 64'(bit_rdy_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    chk("model_crc_zero", 64'(model_crc(27'h0)), 64'h00);
    load(27'h0, 8'h00, 0);
    chk("t1_vld_hold", 64'(key_vld_o), 64'd1);

    load(27'h0, 8'h01, 0);
    chk("t2_err_sticky", 64'(key_err_o), 64'd1);
    chk("t2_p_zero", 64'(p_o), 64'd0);
    pulse_start();
    chk("t2_err_cleared_by_start", 64'(key_err_o), 64'd0);
    bit_vld_i = 1'b0;

    for (int i = 0; i < 8; i++) begin
      key = 27'($urandom);
      crc = model_crc(key);
      if (i % 4 == 3) crc = crc ^ (8'h01 << $urandom_range(7));
      load(key, crc, 50);
      chk("t3_busy_after", 64'(busy_o), 64'd0);
    end

    load(27'h5a5a5a5, model_crc(27'h5a5a5a5), 0);
    pulse_start();
    chk("t4_vld_dropped", 64'(key_vld_o), 64'd0);
    send_bits(27'h7ffffff, 8'h00, 13, 30, acc);
    key = 27'($urandom);
    load(key, model_crc(key), 30);
    chk("t4_second_key_p", 64'(p_o), 64'(key[3:0]));
    chk("t4_second_key_x", 64'(x_o), 64'(key[26:4]));

    pulse_start();
    send_bits(27'h1234567, 8'hff, 30, 20, acc);
    chk("t5_busy_before_rst", 64'(busy_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 64'(busy_o), 64'd0);
    chk("t5_rst_rdy", 64'(bit_rdy_o), 64'd0);
    chk("t5_rst_px", 64'({p_o, x_o}), 64'd0);
    chk("t5_rst_vld", 64'(key_vld_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    key = 27'($urandom) | 27'h1;
    load(key, model_crc(key), 25);

    p_hold = p_o;
    x_hold = x_o;
    for (int i = 0; i < 6; i++) begin
      bit_vld_i = 1'b1;
      bit_i     = 1'($urandom);
      @(negedge clk);
    end
    bit_vld_i = 1'b0;
    chk("t6_idle_bits_p", 64'(p_o), 64'(p_hold));
    chk("t6_idle_bits_x", 64'(x_o), 64'(x_hold));
    chk("t6_idle_busy", 64'(busy_o), 64'd0);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("t6_start_vld", 64'(key_vld_o), 64'd0);
    chk("t6_start_px", 64'({p_o, x_o}), 64'd0);
    @(negedge clk);
    key = 27'($urandom);
    load(key, model_crc(key), 50);

    repeat (5) @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    chk("no_partial_key", 64'(zero_viol), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
